// File: rtl/lc3_memaccess_ctrl.sv
// LC-3 data-memory access sequencer for LD/LDR, LDI, ST/STR and STI.
// Optional stall timeout with an err output when LC3_MEMACCESS_TIMEOUT_EN is defined.
module lc3_memaccess_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  mem_op,
   input  logic [15:0] M_Addr,
   input  logic [15:0] M_Data,
   input  logic        DMem_ready,
   input  logic [15:0] memout,
   output logic [15:0] DMem_addr,
   output logic [15:0] Dmem_din,
   output logic        DMem_rd,
   output logic        DMem_en,
   output logic        busy,
   output logic        done,
`ifdef LC3_MEMACCESS_TIMEOUT_EN
   output logic        err,
`endif
   output logic [15:0] load_data
);

   localparam logic [1:0] OP_LD  = 2'b00;
   localparam logic [1:0] OP_LDI = 2'b01;
   localparam logic [1:0] OP_ST  = 2'b10;
   localparam logic [1:0] OP_STI = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_IND  = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_op;
   logic [15:0] r_addr;
   logic [15:0] r_data;
   logic [15:0] r_load;
   logic        w_tmo;

`ifdef LC3_MEMACCESS_TIMEOUT_EN
   logic [3:0]  r_cnt;
   logic        r_err;
   logic        w_wait;

   assign w_wait = (r_state == S_RD) || (r_state == S_IND) ||
                   (r_state == S_WR);
   // The 15th consecutive stall cycle forces completion.
   assign w_tmo  = w_wait && !DMem_ready && (r_cnt == 4'd14);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_cnt <= 4'd0;
         r_err <= 1'b0;
      end else begin
         r_err <= w_tmo;
         if (w_next != r_state)
            r_cnt <= 4'd0;
         else if (w_wait && !DMem_ready)
            r_cnt <= r_cnt + 4'd1;
      end
   end

   assign err = r_err;
`else
   assign w_tmo = 1'b0;
`endif

   // State register
   always_ff @(posedge clock) begin
      if (!reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start)
               w_next = (mem_op == OP_ST) ? S_WR : S_RD;
         end
         S_RD: begin
            if (DMem_ready) begin
               case (r_op)
                  OP_LDI:  w_next = S_IND;
                  OP_STI:  w_next = S_WR;
                  default: w_next = S_DONE;
               endcase
            end
         end
         S_IND: begin
            if (DMem_ready)
               w_next = S_DONE;
         end
         S_WR: begin
            if (DMem_ready)
               w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (w_tmo)
         w_next = S_DONE;
   end

   // Request latches, pointer chase and load capture
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_op   <= 2'b00;
         r_addr <= 16'h0000;
         r_data <= 16'h0000;
         r_load <= 16'h0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op   <= mem_op;
                  r_addr <= M_Addr;
                  r_data <= M_Data;
               end
            end
            S_RD: begin
               if (DMem_ready) begin
                  if (r_op == OP_LD)
                     r_load <= memout;
                  else
                     r_addr <= memout;
               end
            end
            S_IND: begin
               if (DMem_ready)
                  r_load <= memout;
            end
            default: ;
         endcase
      end
   end

   // Output decode
   always_comb begin
      DMem_en   = 1'b0;
      DMem_rd   = 1'b1;
      Dmem_din  = 16'h0000;
      DMem_addr = r_addr;
      case (r_state)
         S_RD, S_IND: begin
            DMem_en = 1'b1;
         end
         S_WR: begin
            DMem_en  = 1'b1;
            DMem_rd  = 1'b0;
            Dmem_din = r_data;
         end
         default: ;
      endcase
   end

   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign load_data = r_load;

endmodule

// File: tb/tb_lc3_memaccess_ctrl.sv
// Randomised bench for lc3_memaccess_ctrl against a transaction-level
// model: each request expands into an ordered list of expected bus accesses.
module tb_lc3_memaccess_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  mem_op;
   logic [15:0] M_Addr;
   logic [15:0] M_Data;
   logic        DMem_ready;
   logic [15:0] memout;
   logic [15:0] DMem_addr;
   logic [15:0] Dmem_din;
   logic        DMem_rd;
   logic        DMem_en;
   logic        busy;
   logic        done;
   logic [15:0] load_data;
`ifdef LC3_MEMACCESS_TIMEOUT_EN
   logic        err;
`endif

   lc3_memaccess_ctrl dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .mem_op     (mem_op),
      .M_Addr     (M_Addr),
      .M_Data     (M_Data),
      .DMem_ready (DMem_ready),
      .memout     (memout),
      .DMem_addr  (DMem_addr),
      .Dmem_din   (Dmem_din),
      .DMem_rd    (DMem_rd),
      .DMem_en    (DMem_en),
      .busy       (busy),
      .done       (done),
`ifdef LC3_MEMACCESS_TIMEOUT_EN
      .err        (err),
`endif
      .load_data  (load_data)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        rd;
      logic [15:0] addr;
      logic [15:0] din;
      logic        cap;
      logic [15:0] val;
   } acc_t;

   int          n_cmp = 0;
   int          n_err = 0;
   int          phase = 0;
   acc_t        q[$];
   logic [15:0] m_load = 16'h0000;
   logic [15:0] m_last = 16'h0000;
   logic        m_err = 1'b0;
   int          m_stall = 0;
   logic [15:0] mem [logic [15:0]];
   int          rdy_mode = 0;
   int          stall_n = 0;

   function automatic logic [15:0] mrd(input logic [15:0] a);
      logic [15:0] h;
      if (mem.exists(a))
         return mem[a];
      h = a * 16'h9E37;
      return h ^ 16'h5A5A;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic respond();
      if (DMem_en === 1'b1) begin
         case (rdy_mode)
            1: DMem_ready = 1'b1;
            2: begin
               if (stall_n > 0) begin
                  DMem_ready = 1'b0;
                  stall_n--;
               end else
                  DMem_ready = 1'b1;
            end
            3: DMem_ready = 1'b0;
            default: DMem_ready = ($urandom_range(0, 99) < 55);
         endcase
      end else
         DMem_ready = 1'($urandom_range(0, 1));
      if (DMem_ready && DMem_en === 1'b1 && DMem_rd === 1'b1)
         memout = mrd(DMem_addr);
      else
         memout = 16'($urandom);
   endtask

   task automatic build();
      logic [15:0] p;
      case (mem_op)
         2'b00: q.push_back('{1'b1, M_Addr, 16'h0, 1'b1, mrd(M_Addr)});
         2'b01: begin
            p = mrd(M_Addr);
            q.push_back('{1'b1, M_Addr, 16'h0, 1'b0, 16'h0});
            q.push_back('{1'b1, p, 16'h0, 1'b1, mrd(p)});
         end
         2'b10: q.push_back('{1'b0, M_Addr, M_Data, 1'b0, 16'h0});
         default: begin
            p = mrd(M_Addr);
            q.push_back('{1'b1, M_Addr, 16'h0, 1'b0, 16'h0});
            q.push_back('{1'b0, p, M_Data, 1'b0, 16'h0});
         end
      endcase
   endtask

   // Predicts the view after the coming rising edge.
   task automatic model();
      acc_t h;
      if (!reset) begin
         phase = 0;
         q.delete();
         m_load = 16'h0000;
         m_last = 16'h0000;
         m_err = 1'b0;
         m_stall = 0;
      end else begin
         case (phase)
            0: begin
               if (start) begin
                  build();
                  phase = 1;
               end
            end
            1: begin
               if (DMem_ready) begin
                  h = q.pop_front();
                  m_last = h.addr;
                  m_stall = 0;
                  if (h.rd && h.cap)
                     m_load = h.val;
                  if (!h.rd)
                     mem[h.addr] = h.din;
                  if (q.size() == 0)
                     phase = 2;
               end else begin
`ifdef LC3_MEMACCESS_TIMEOUT_EN
                  m_stall++;
                  if (m_stall == 15) begin
                     m_last = q[0].addr;
                     q.delete();
                     m_err = 1'b1;
                     phase = 2;
                  end
`endif
               end
            end
            default: begin
               phase = 0;
               m_err = 1'b0;
               m_stall = 0;
            end
         endcase
      end
   endtask

   task automatic check();
      logic        erd;
      logic [15:0] ea;
      logic [15:0] ed;
      if (phase == 1) begin
         erd = q[0].rd;
         ea  = q[0].addr;
         ed  = q[0].rd ? 16'h0000 : q[0].din;
      end else begin
         erd = 1'b1;
         ea  = m_last;
         ed  = 16'h0000;
      end
      chk("busy", 16'(busy), 16'(phase != 0));
      chk("done", 16'(done), 16'(phase == 2));
      chk("en", 16'(DMem_en), 16'(phase == 1));
      chk("rd", 16'(DMem_rd), 16'(erd));
      chk("addr", DMem_addr, ea);
      chk("din", Dmem_din, ed);
      chk("load", load_data, m_load);
`ifdef LC3_MEMACCESS_TIMEOUT_EN
      chk("err", 16'(err), 16'(m_err));
`endif
   endtask

   task automatic cyc();
      respond();
      model();
      @(negedge clock);
      check();
   endtask

   int dones;
   int hit;

   initial begin
      reset = 1'b0;
      start = 1'b0;
      mem_op = 2'b00;
      M_Addr = 16'h0000;
      M_Data = 16'h0000;
      DMem_ready = 1'b0;
      memout = 16'h0000;
      cyc();
      cyc();
      chk("rst_en", 16'(DMem_en), 16'h0000);
      chk("rst_rd", 16'(DMem_rd), 16'h0001);
      chk("rst_addr", DMem_addr, 16'h0000);
      chk("rst_busy", 16'(busy), 16'h0000);
      reset = 1'b1;
      cyc();

      // LD with ready tied high
      mem[16'h3000] = 16'hBEEF;
      mem[16'h3001] = 16'h4000;
      mem[16'h4000] = 16'h1234;
      mem[16'h3002] = 16'h5000;
      rdy_mode = 1;
      start = 1'b1; mem_op = 2'b00; M_Addr = 16'h3000;
      cyc();
      start = 1'b0;
      chk("ld_addr", DMem_addr, 16'h3000);
      chk("ld_rd", 16'(DMem_rd), 16'h0001);
      cyc();
      chk("ld_done", 16'(done), 16'h0001);
      chk("ld_data", load_data, 16'hBEEF);
      cyc();

      // LDI pointer chase
      start = 1'b1; mem_op = 2'b01; M_Addr = 16'h3001;
      cyc();
      start = 1'b0;
      chk("ldi_a1", DMem_addr, 16'h3001);
      cyc();
      chk("ldi_a2", DMem_addr, 16'h4000);
      chk("ldi_nd", 16'(done), 16'h0000);
      cyc();
      chk("ldi_done", 16'(done), 16'h0001);
      chk("ldi_data", load_data, 16'h1234);
      cyc();

      // STI pointer then write
      start = 1'b1; mem_op = 2'b11; M_Addr = 16'h3002; M_Data = 16'h00FF;
      cyc();
      start = 1'b0;
      chk("sti_a1", DMem_addr, 16'h3002);
      cyc();
      chk("sti_wa", DMem_addr, 16'h5000);
      chk("sti_wd", Dmem_din, 16'h00FF);
      chk("sti_rd", 16'(DMem_rd), 16'h0000);
      cyc();
      chk("sti_done", 16'(done), 16'h0001);
      chk("sti_load", load_data, 16'h1234);
      cyc();

      // ST with five stall cycles and an ignored second start
      rdy_mode = 2; stall_n = 5;
      start = 1'b1; mem_op = 2'b10; M_Addr = 16'h3100; M_Data = 16'hCAFE;
      cyc();
      start = 1'b0;
      dones = 0;
      for (int k = 1; k <= 6; k++) begin
         chk("st_en", 16'(DMem_en), 16'h0001);
         chk("st_rd", 16'(DMem_rd), 16'h0000);
         chk("st_addr", DMem_addr, 16'h3100);
         chk("st_din", Dmem_din, 16'hCAFE);
         if (k == 3) begin
            start = 1'b1; mem_op = 2'b00; M_Addr = 16'h1111;
         end
         cyc();
         start = 1'b0;
         dones += int'(done);
      end
      cyc();
      dones += int'(done);
      cyc();
      dones += int'(done);
      chk("st_dones", 16'(dones), 16'h0001);
      chk("st_idle", 16'(busy), 16'h0000);

      // Reset while in IND of an LDI
      rdy_mode = 1;
      start = 1'b1; mem_op = 2'b01; M_Addr = 16'h3001;
      cyc();
      start = 1'b0;
      cyc();
      chk("ind_addr", DMem_addr, 16'h4000);
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      chk("ar_en", 16'(DMem_en), 16'h0000);
      chk("ar_rd", 16'(DMem_rd), 16'h0001);
      chk("ar_addr", DMem_addr, 16'h0000);
      chk("ar_din", Dmem_din, 16'h0000);
      chk("ar_busy", 16'(busy), 16'h0000);
      chk("ar_done", 16'(done), 16'h0000);
      chk("ar_load", load_data, 16'h0000);
      cyc();
      chk("ar_nodone", 16'(done), 16'h0000);

`ifdef LC3_MEMACCESS_TIMEOUT_EN
      start = 1'b1; mem_op = 2'b00; M_Addr = 16'h3000;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      rdy_mode = 3;
      start = 1'b1; mem_op = 2'b00; M_Addr = 16'h2000;
      cyc();
      start = 1'b0;
      hit = 0;
      for (int k = 2; k <= 20; k++) begin
         cyc();
         if (hit == 0 && done === 1'b1) begin
            hit = k;
            chk("tmo_err", 16'(err), 16'h0001);
            chk("tmo_load", load_data, 16'hBEEF);
         end
      end
      chk("tmo_cycle", 16'(hit), 16'd16);
`endif

      // Random traffic
      rdy_mode = 0;
      for (int i = 0; i < 1500; i++) begin
         reset = ($urandom_range(0, 199) != 0);
         start = ($urandom_range(0, 2) == 0);
         mem_op = 2'($urandom);
         if ($urandom_range(0, 3) == 0)
            M_Addr = 16'h3000 + 16'($urandom_range(0, 7));
         else
            M_Addr = 16'($urandom);
         M_Data = 16'($urandom);
         cyc();
      end
      reset = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 40; i++)
         cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
